// File: rtl/dcbarb_rr_sched.sv
// Round-robin scheduler for the DCB pop channel: registered one-hot grant held until popped.
// Define DCBARB_LOCK_EN to add the lock port and multi-beat bursts of up to MAX_BURST.
module dcbarb_rr_sched #(
  parameter int CNT       = 8,
  parameter int MAX_BURST = 4,
  parameter int IW        = $clog2(CNT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CNT-1:0]                 req,
  input  logic                           rdy,
`ifdef DCBARB_LOCK_EN
  input  logic                           lock,
`endif
  output logic [CNT-1:0]                 grant,
  output logic [IW-1:0]                  grant_idx,
  output logic                           pop,
  output logic [$clog2(MAX_BURST+1)-1:0] burst_cnt
);

  localparam int BW = $clog2(MAX_BURST+1);

  typedef enum logic {IDLE, GNT} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  next_ptr;
  logic [IW-1:0]  base;
  logic [IW-1:0]  sel_idx;
  logic [IW-1:0]  probe;
  logic [CNT-1:0] sel_oh;
  logic           sel_found;
  logic           eob;
  logic           release_gnt;

  assign pop      = (|grant) & rdy;
  assign next_ptr = (grant_idx == IW'(CNT-1)) ? '0 : grant_idx + 1'b1;

  // On release the search starts just past the current winner, so re-selection is back-to-back
  assign base = (state == GNT) ? next_ptr : ptr;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int k = 0; k < CNT; k++) begin
      probe = IW'((int'(base) + k) % CNT);
      if (!sel_found && req[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  assign sel_oh = {{(CNT-1){1'b0}}, 1'b1} << sel_idx;

`ifdef DCBARB_LOCK_EN
  assign eob = !lock || (burst_cnt == BW'(MAX_BURST-1));
`else
  assign eob = 1'b1;
`endif

  assign release_gnt = (pop & eob) | (~req[grant_idx] & ~pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state     <= GNT;
            grant     <= sel_oh;
            grant_idx <= sel_idx;
          end
        end
        GNT: begin
          if (release_gnt) begin
            ptr       <= next_ptr;
            burst_cnt <= '0;
            if (sel_found) begin
              grant     <= sel_oh;
              grant_idx <= sel_idx;
            end else begin
              state     <= IDLE;
              grant     <= '0;
              grant_idx <= '0;
            end
          end else if (pop && burst_cnt != BW'(MAX_BURST)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
